// File: rtl/iterative_normalizer_if.sv
// Handshake bundle for the iterative normalizer: operand channel in, result channel out.
// master drives operands and accepts results; slave is the normalizer itself.
interface iterative_normalizer_if #(
   parameter int SIZE  = 31,
   parameter int CNT_W = $clog2(SIZE + 1)
);
   logic             in_valid;
   logic             in_ready;
   logic [SIZE-1:0]  in_num;
   logic             out_valid;
   logic             out_ready;
   logic [SIZE-1:0]  out_num;
   logic [CNT_W-1:0] out_shift;
   logic             out_zero;

   modport master (
      output in_valid,
      output in_num,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_num,
      input  out_shift,
      input  out_zero
   );

   modport slave (
      input  in_valid,
      input  in_num,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_num,
      output out_shift,
      output out_zero
   );
endinterface

// File: rtl/iterative_normalizer.sv
// Multi-cycle left-normalizer: shifts a mantissa left one bit per cycle until its MSB
// is set, reporting the shift count for exponent adjustment.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | shifting value left until MSB is 1, counting shifts
// DONE  | result presented with out_valid, held until out_ready
module iterative_normalizer #(
   parameter int SIZE  = 31,
   parameter int CNT_W = $clog2(SIZE + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   iterative_normalizer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [SIZE-1:0]  value;
   logic [CNT_W-1:0] count;
   logic             zero_r;
   logic             in_ready_r;
   logic             out_valid_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         value       <= '0;
         count       <= '0;
         zero_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  value      <= bus.in_num;
                  in_ready_r <= 1'b0;
                  // An all-zero operand can never reach MSB=1, so it bypasses SHIFT.
                  if (bus.in_num == '0) begin
                     zero_r      <= 1'b1;
                     count       <= CNT_W'(SIZE);
                     out_valid_r <= 1'b1;
                     state       <= DONE;
                  end else begin
                     zero_r <= 1'b0;
                     count  <= '0;
                     state  <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (value[SIZE-1]) begin
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  value <= {value[SIZE-2:0], 1'b0};
                  count <= count + CNT_W'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_num   = value;
   assign bus.out_shift = count;
   assign bus.out_zero  = zero_r;
endmodule

// File: tb/tb_iterative_normalizer.sv
// Directed and random checks of the iterative normalizer against a leading-zero model.
module tb_iterative_normalizer;
   localparam int SIZE  = 31;
   localparam int CNT_W = $clog2(SIZE + 1);

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   iterative_normalizer_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

   iterative_normalizer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operand through the block; stall = cycles out_ready is held low once the result shows.
   task automatic do_op(input logic [SIZE-1:0] num, input int stall, input string tag);
      int              k;
      int              lat;
      int              exp_lat;
      logic [SIZE-1:0] exp_num;
      logic            exp_zero;
      k = SIZE;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (num[i]) begin
            k = SIZE - 1 - i;
            break;
         end
      end
      exp_zero = (num == '0);
      exp_num  = exp_zero ? '0 : (num << k);
      exp_lat  = exp_zero ? 1 : k + 2;

      @(negedge clk);
      check({tag, "_in_ready_idle"}, longint'(bus.in_ready), 1);
      bus.in_valid  = 1'b1;
      bus.in_num    = num;
      bus.out_ready = (stall == 0);
      tick();
      bus.in_valid = 1'b0;
      bus.in_num   = SIZE'($urandom);
      lat = 1;
      while (!bus.out_valid && lat <= SIZE + 8) begin
         tick();
         lat++;
      end
      check({tag, "_out_valid_seen"}, longint'(bus.out_valid), 1);
      if (!bus.out_valid) return;
      check({tag, "_latency"}, longint'(lat), longint'(exp_lat));
      check({tag, "_out_num"}, longint'(bus.out_num), longint'(exp_num));
      check({tag, "_out_shift"}, longint'(bus.out_shift), longint'(k));
      check({tag, "_out_zero"}, longint'(bus.out_zero), longint'(exp_zero));
      check({tag, "_in_ready_busy"}, longint'(bus.in_ready), 0);
      if (!exp_zero) check({tag, "_msb"}, longint'(bus.out_num[SIZE-1]), 1);
      for (int s = 0; s < stall; s++) begin
         tick();
         check({tag, "_hold_valid"}, longint'(bus.out_valid), 1);
         check({tag, "_hold_num"}, longint'(bus.out_num), longint'(exp_num));
         check({tag, "_hold_shift"}, longint'(bus.out_shift), longint'(k));
         check({tag, "_hold_in_ready"}, longint'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      tick();
      check({tag, "_released_valid"}, longint'(bus.out_valid), 0);
      check({tag, "_released_in_ready"}, longint'(bus.in_ready), 1);
   endtask

   initial begin
      logic            seen_valid;
      logic [SIZE-1:0] rnd;
      total = 0;
      bad   = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_num    = SIZE'(1);
      bus.out_ready = 1'b0;

      for (int c = 0; c < 2; c++) begin
         tick();
         check("rst_in_ready", longint'(bus.in_ready), 1);
         check("rst_out_valid", longint'(bus.out_valid), 0);
         check("rst_out_num", longint'(bus.out_num), 0);
         check("rst_out_shift", longint'(bus.out_shift), 0);
         check("rst_out_zero", longint'(bus.out_zero), 0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      tick();
      check("post_rst_idle", longint'(bus.in_ready), 1);
      check("post_rst_no_valid", longint'(bus.out_valid), 0);

      do_op(SIZE'(32'h4000_0000), 0, "msb_set");
      do_op(SIZE'(32'h0000_0001), 0, "worst");
      do_op(SIZE'(32'h0001_2345), 0, "mid");
      do_op(SIZE'(0), 0, "zero");
      do_op(SIZE'(32'h0000_0F00), 5, "bp");
      do_op(SIZE'(32'h0000_0003), 0, "b2b");

      // Abandon an operand mid-shift.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_num   = SIZE'(1);
      tick();
      bus.in_valid = 1'b0;
      check("mid_shift_busy", longint'(bus.in_ready), 0);
      repeat (5) tick();
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      check("abort_in_ready", longint'(bus.in_ready), 1);
      check("abort_out_valid", longint'(bus.out_valid), 0);
      check("abort_out_shift", longint'(bus.out_shift), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      repeat (40) begin
         tick();
         if (bus.out_valid) seen_valid = 1'b1;
      end
      check("abort_no_result", longint'(seen_valid), 0);

      for (int n = 0; n < 100; n++) begin
         if ($urandom_range(0, 9) == 0) rnd = '0;
         else rnd = SIZE'($urandom) >> $urandom_range(0, SIZE - 1);
         do_op(rnd, int'($urandom_range(0, 3)), "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/iterative_normalizer.md
Name: iterative_normalizer

Overview:
- Multi-cycle left-normalizer for the FPU datapath.
- Takes an unsigned SIZE-bit mantissa and shifts it left one bit per cycle until its MSB is 1.
- Returns the normalized value and the shift count, so the exponent can be adjusted.
- It is the inverse-direction companion of the leading-one finder: it produces the aligned value instead of reporting the one's position. Uses valid/ready handshakes on both sides.

Parameters:
- SIZE, 31, mantissa width in bits (>= 2).
- CNT_W, $clog2(SIZE+1), width of shift count; must hold the value SIZE.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_num is valid.
- in_ready  output  1  block can accept an operand.
- in_num  input  SIZE  unsigned mantissa to normalize.
- out_valid  output  1  result registers are valid.
- out_ready  input  1  consumer accepts the result.
- out_num  output  SIZE  normalized value; MSB = 1 unless zero.
- out_shift  output  CNT_W  number of left shifts applied (= leading-zero count).
- out_zero  output  1  input was all zeros.

Behaviour:
- Reset: synchronous, active-low. When rst_n=0 at a clk edge:
  - state <= IDLE;
  - out_num, out_shift, out_zero <= 0;
  - out_valid <= 0, in_ready <= 1 (in_ready is a function of state).
  - Reset mid-SHIFT or mid-DONE abandons the operation; no output is produced for it.
- States: IDLE, SHIFT, DONE. One operand in flight; no overlap.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: load the value register with in_num and set count <= 0.
  - If in_num == 0: out_zero <= 1, count <= SIZE, go to DONE.
  - Otherwise: out_zero <= 0, go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0. Evaluated each cycle.
  - If value[SIZE-1] == 1: go to DONE; value and count unchanged.
  - Else: value <= value << 1 with 0 shifted in at LSB; count <= count + 1.
  - count never exceeds SIZE-1 for nonzero input.
- DONE:
  - out_valid=1, in_ready=0.
  - out_num = value register, out_shift = count.
  - Outputs are held stable while out_ready=0, for any number of cycles.
  - On out_valid && out_ready: go to IDLE. A new operand can be accepted no earlier than the following cycle.
- Latency (acceptance edge to first cycle with out_valid=1), k = leading zeros of in_num:
  - zero input: 1 cycle;
  - nonzero input: k+2 cycles (k = 0 gives 2, maximum SIZE+1).
- Invariants:
  - out_num == in_num << out_shift, truncated to SIZE bits.
  - For nonzero input, out_num[SIZE-1] == 1.
- in_num is sampled only at the acceptance edge. Later changes on in_num or in_valid while busy are ignored.
- Simultaneous reset and handshake: reset wins.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1, in_num=31'h1 -> in_ready=1, out_valid=0, out_num=0, out_shift=0, out_zero=0; nothing is accepted.
- MSB already set: in_num=31'h40000000, out_ready=1 -> out_num=31'h40000000, out_shift=0, out_zero=0, out_valid exactly 2 cycles after acceptance.
- Worst case: in_num=31'h00000001 -> out_num=31'h40000000, out_shift=30, latency 32 cycles. Also in_num=31'h00012345 -> out_num=31'h48D14000, out_shift=14.
- Zero: in_num=0 -> out_zero=1, out_shift=31, out_num=0, latency 1 cycle.
- Backpressure: result for 31'h00000F00, out_ready=0 for 5 cycles -> out_valid, out_num=31'h78000000 and out_shift=19 stay constant, in_ready=0. out_ready=1 -> IDLE next cycle, back-to-back operand accepted.
- Reset mid-operation and random: rst_n=0 during SHIFT of 31'h1 -> IDLE, no out_valid. Then 100 $random operands with random out_ready stalls -> every result satisfies the invariants.
